// File: rtl/fc8_vram_arbiter.sv
// VRAM slot arbiter: video scanout has absolute priority, the CPU gets
// leftover slots through a four-state handshake FSM.
module fc8_vram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int STALL_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_starved,
    output logic              vram_en,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } cpu_state_t;

    cpu_state_t state, state_nxt;

    logic       grant_cpu;
    logic       cpu_wait;
    logic       cpu_rd;
    logic       vid_p1;
    logic       vid_p2;
    logic [7:0] wait_cnt;
    logic [8:0] wait_inc;

    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req && !vid_req) begin
                    grant_cpu = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_wait = (state == IDLE) && cpu_req && vid_req;
    assign wait_inc = {1'b0, wait_cnt} + 9'd1;
    assign cpu_ack  = (state == ACK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vram_en     <= 1'b0;
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_wdata  <= '0;
            vid_p1      <= 1'b0;
            vid_p2      <= 1'b0;
            vid_rvalid  <= 1'b0;
            vid_rdata   <= '0;
            cpu_rd      <= 1'b0;
            cpu_rdata   <= '0;
            wait_cnt    <= '0;
            cpu_starved <= 1'b0;
        end else begin
            vram_en <= 1'b0;
            vram_we <= 1'b0;
            if (vid_req) begin
                vram_en   <= 1'b1;
                vram_addr <= vid_addr;
            end else if (grant_cpu) begin
                vram_en   <= 1'b1;
                vram_we   <= cpu_we;
                vram_addr <= cpu_addr;
                if (cpu_we) begin
                    vram_wdata <= cpu_wdata;
                end
            end

            // Read data returns two cycles after the slot decision.
            vid_p1     <= vid_req;
            vid_p2     <= vid_p1;
            vid_rvalid <= vid_p2;
            if (vid_p2) begin
                vid_rdata <= vram_rdata;
            end

            if (grant_cpu) begin
                cpu_rd <= !cpu_we;
            end
            if (state == WAIT && cpu_rd) begin
                cpu_rdata <= vram_rdata;
            end

            // Saturating count means the limit is crossed once per wait run.
            cpu_starved <= 1'b0;
            if (grant_cpu) begin
                wait_cnt <= '0;
            end else if (cpu_wait && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_inc[7:0];
                if (wait_inc == 9'(STALL_LIMIT)) begin
                    cpu_starved <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc8_vram_arbiter.sv
// Directed bench for fc8_vram_arbiter with a behavioural synchronous VRAM.
// Expected read data comes from a fixed address-derived fill pattern.
module tb_fc8_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_starved;
    logic        vram_en;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;

    logic [7:0]  mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fc8_vram_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .STALL_LIMIT(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_rvalid(vid_rvalid),
        .vid_rdata(vid_rdata),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .cpu_starved(cpu_starved),
        .vram_en(vram_en),
        .vram_we(vram_we),
        .vram_addr(vram_addr),
        .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata)
    );

    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else vram_rdata <= mem[vram_addr];
        end
    end

    function automatic logic [7:0] fill(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [62:0] outs;
        rst_n = 1'b0;
        tick();
        tick();
        outs = {vid_rvalid, vid_rdata, cpu_ack, cpu_rdata, cpu_starved,
                vram_en, vram_we, vram_addr, vram_wdata};
        vectors++;
        if (outs !== 63'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
        tick();
        vectors++;
        if ({vram_en, vram_we, vram_addr, vram_wdata} !== {2'b11, 16'h1234, 8'hA5}) begin
            miscompares++;
            $display("FAIL wr_issue: got %b%b %h %h expected 11 1234 a5",
                     vram_en, vram_we, vram_addr, vram_wdata);
        end
        tick();
        vectors++;
        if (cpu_ack !== 1'b0 || vram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_wait: got ack=%b en=%b expected 0 0", cpu_ack, vram_en);
        end
        tick();
        vectors++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL wr_ack: got ack=%b rdata=%h expected 1 00", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        tick();
        vectors++;
        if (cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_early_ack: got %b expected 0", cpu_ack);
        end
        tick();
        vectors++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL rd_ack: got ack=%b rdata=%h expected 1 a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        vid_req = 1'b1; vid_addr = 16'h0042;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick();
        vectors++;
        if ({vram_en, vram_we, vram_addr} !== {2'b10, 16'h0042}) begin
            miscompares++;
            $display("FAIL sim_vid_slot: got %b%b %h expected 10 0042",
                     vram_en, vram_we, vram_addr);
        end
        vid_req = 1'b0;
        tick();
        vectors++;
        if ({vram_en, vram_we, vram_addr} !== {2'b10, 16'h1234}) begin
            miscompares++;
            $display("FAIL sim_cpu_slot: got %b%b %h expected 10 1234",
                     vram_en, vram_we, vram_addr);
        end
        tick();
        vectors++;
        if ({vid_rvalid, vid_rdata, cpu_ack} !== {1'b1, fill(16'h0042), 1'b0}) begin
            miscompares++;
            $display("FAIL sim_vid_data: got v=%b d=%h ack=%b expected 1 %h 0",
                     vid_rvalid, vid_rdata, cpu_ack, fill(16'h0042));
        end
        tick();
        vectors++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL sim_cpu_ack: got ack=%b rdata=%h expected 1 a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read_with_video();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0077;
        tick();
        vectors++;
        if ({vram_en, vram_we, vram_addr} !== {2'b10, 16'h0077}) begin
            miscompares++;
            $display("FAIL mix_cpu_slot: got %b%b %h expected 10 0077",
                     vram_en, vram_we, vram_addr);
        end
        vid_req = 1'b1; vid_addr = 16'h0010;
        tick();
        vectors++;
        if ({vram_en, vram_addr} !== {1'b1, 16'h0010}) begin
            miscompares++;
            $display("FAIL mix_vid0_slot: got %b %h expected 1 0010", vram_en, vram_addr);
        end
        vid_addr = 16'h0011;
        tick();
        vectors++;
        if ({vram_en, vram_addr, cpu_ack, cpu_rdata} !== {1'b1, 16'h0011, 1'b1, fill(16'h0077)}) begin
            miscompares++;
            $display("FAIL mix_cpu_ack: got en=%b a=%h ack=%b d=%h expected 1 0011 1 %h",
                     vram_en, vram_addr, cpu_ack, cpu_rdata, fill(16'h0077));
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        tick();
        vectors++;
        if ({vram_en, vram_we, vram_addr, vid_rvalid, vid_rdata, cpu_ack} !==
            {2'b00, 16'h0011, 1'b1, fill(16'h0010), 1'b0}) begin
            miscompares++;
            $display("FAIL mix_idle_slot: got en=%b we=%b a=%h v=%b d=%h ack=%b",
                     vram_en, vram_we, vram_addr, vid_rvalid, vid_rdata, cpu_ack);
        end
        tick();
        vectors++;
        if ({vid_rvalid, vid_rdata} !== {1'b1, fill(16'h0011)}) begin
            miscompares++;
            $display("FAIL mix_vid1_data: got %b %h expected 1 %h",
                     vid_rvalid, vid_rdata, fill(16'h0011));
        end
        tick();
        vectors++;
        if (vid_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mix_vid_end: got %b expected 0", vid_rvalid);
        end
    endtask

    task automatic test_video_stream();
        logic [15:0] k;
        vid_req = 1'b1; vid_addr = 16'h0000;
        for (int t = 1; t <= 260; t++) begin
            tick();
            if (t <= 256) begin
                k = 16'(t - 1);
                vectors++;
                if ({vram_en, vram_we, vram_addr} !== {2'b10, k}) begin
                    miscompares++;
                    $display("FAIL stream_slot t=%0d: got %b%b %h expected 10 %h",
                             t, vram_en, vram_we, vram_addr, k);
                end
                vectors++;
                if (cpu_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_no_grant t=%0d: got ack %b expected 0", t, cpu_ack);
                end
            end
            if (t >= 3 && t <= 258) begin
                k = 16'(t - 3);
                vectors++;
                if ({vid_rvalid, vid_rdata} !== {1'b1, fill(k)}) begin
                    miscompares++;
                    $display("FAIL stream_data t=%0d: got %b %h expected 1 %h",
                             t, vid_rvalid, vid_rdata, fill(k));
                end
            end
            if (t == 257) begin
                vectors++;
                if ({vram_en, vram_we, vram_addr} !== {2'b10, 16'h1234}) begin
                    miscompares++;
                    $display("FAIL stream_cpu_slot: got %b%b %h expected 10 1234",
                             vram_en, vram_we, vram_addr);
                end
            end
            if (t == 259) begin
                vectors++;
                if ({vid_rvalid, cpu_ack, cpu_rdata} !== {2'b01, 8'hA5}) begin
                    miscompares++;
                    $display("FAIL stream_cpu_ack: got v=%b ack=%b d=%h expected 0 1 a5",
                             vid_rvalid, cpu_ack, cpu_rdata);
                end
            end
            vid_req  = (t < 256);
            vid_addr = 16'(t);
            if (t == 10) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
            end
            if (t == 259) cpu_req = 1'b0;
        end
    endtask

    task automatic test_starved();
        vid_req = 1'b1; vid_addr = 16'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        for (int t = 1; t <= 74; t++) begin
            tick();
            vectors++;
            if (cpu_starved !== (t == 64)) begin
                miscompares++;
                $display("FAIL starved t=%0d: got %b expected %b", t, cpu_starved, t == 64);
            end
            vectors++;
            if (cpu_ack !== (t == 73)) begin
                miscompares++;
                $display("FAIL starved_ack t=%0d: got %b expected %b", t, cpu_ack, t == 73);
            end
            vid_req  = (t < 70);
            vid_addr = 16'(16'h0100 + t);
            if (t == 73) cpu_req = 1'b0;
        end
    endtask

    task automatic test_reset_in_wait();
        logic [62:0] outs;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick();
        vid_req = 1'b1; vid_addr = 16'h0020;
        tick();
        rst_n = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        tick();
        outs = {vid_rvalid, vid_rdata, cpu_ack, cpu_rdata, cpu_starved,
                vram_en, vram_we, vram_addr, vram_wdata};
        vectors++;
        if (outs !== 63'd0) begin
            miscompares++;
            $display("FAIL rst_wait_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick();
            vectors++;
            if ({cpu_ack, vid_rvalid} !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_discard t=%0d: got ack=%b v=%b expected 0 0",
                         t, cpu_ack, vid_rvalid);
            end
        end
        cpu_req = 1'b1; cpu_addr = 16'h0077;
        tick();
        tick();
        vectors++;
        if (cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_idle_early: got ack %b expected 0", cpu_ack);
        end
        tick();
        vectors++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== fill(16'h0077)) begin
            miscompares++;
            $display("FAIL rst_idle_ack: got ack=%b d=%h expected 1 %h",
                     cpu_ack, cpu_rdata, fill(16'h0077));
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = fill(16'(i));
        vram_rdata = 8'h00;
        rst_n = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_cpu_write_read();
        test_simultaneous();
        test_cpu_read_with_video();
        test_video_stream();
        test_starved();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
